// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the multiplexed 7-segment scanner.
//   NUM_DIGITS : number of digit positions scanned
//   SEG_OFF    : segment bus value with every segment dark (active-low)
//   AN_OFF     : anode bus value with every digit deselected (active-low)
//   scan_state_t : scanner phase within a digit slot
//   an_select  : active-low one-hot anode pattern for a digit index
package seg7_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [5:0] AN_OFF     = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON,
    ST_OFF
  } scan_state_t;

  function automatic logic [5:0] an_select(input logic [2:0] idx);
    logic [5:0] one_hot;
    one_hot = 6'b000001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer -- digit slot counter for the 7-segment scanner.
//   m_clock, p_reset : system clock, asynchronous active-high reset
//   clear    : forces the counter back to slot 0, cnt 0 on the next edge
//   advance  : counts cnt 0..DIV-1, then steps idx 0..NUM_DIGITS-1 with wrap
//   cnt_next, idx_next : values the counter takes at the next edge
//   wrap     : current cycle is the last one of a slot
//   frame    : current cycle is the last one of the last slot
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int DIV = 1024
) (
  input  logic                    m_clock,
  input  logic                    p_reset,
  input  logic                    clear,
  input  logic                    advance,
  output logic [$clog2(DIV)-1:0]  cnt_next,
  output logic [2:0]              idx_next,
  output logic                    wrap,
  output logic                    frame
);

  localparam int               CW       = $clog2(DIV);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  assign wrap  = (cnt == CNT_LAST);
  assign frame = wrap && (idx == IDX_LAST);

  // clear wins over advance so a dropped enable always returns to slot 0.
  always_comb begin
    cnt_next = cnt;
    idx_next = idx;
    if (clear) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (advance) begin
      if (wrap) begin
        cnt_next = '0;
        idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan -- time-multiplexed driver for a 6-digit common-anode display.
//   m_clock, p_reset : system clock, asynchronous active-high reset
//   enable   : 0 blanks the display and parks the scanner at slot 0
//   digit_0..digit_5 : active-high segment patterns (bit7 = dp), digit_0 = LSD
//   bright   : duty control, 0 = 1/8 of the lit window, 7 = all of it
//   seg      : shared segment bus, active-low
//   an       : digit anode selects, active-low, at most one low
//   frame    : one-cycle pulse in the last cycle of a full scan
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = 1024,
  parameter int BLANK = 64
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       enable,
  input  logic [7:0] digit_0,
  input  logic [7:0] digit_1,
  input  logic [7:0] digit_2,
  input  logic [7:0] digit_3,
  input  logic [7:0] digit_4,
  input  logic [7:0] digit_5,
  input  logic [2:0] bright,
  output logic [7:0] seg,
  output logic [5:0] an,
  output logic       frame
);

  localparam int CW     = $clog2(DIV);
  localparam int ONSTEP = (DIV - BLANK) / 8;

  scan_state_t   state, state_next;
  logic [7:0]    seg_l, seg_l_next;
  logic [2:0]    bright_l, bright_l_next;
  logic [CW-1:0] cnt_next;
  logic [2:0]    idx_next;
  logic          wrap;
  logic          slot_start;
  logic [7:0]    digit_sel;
  logic [31:0]   on_end;
  logic [7:0]    seg_d;
  logic [5:0]    an_d;

  seg7_slot_timer #(.DIV(DIV)) u_timer (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .clear    (!enable),
    .advance  (enable && (state != ST_IDLE)),
    .cnt_next (cnt_next),
    .idx_next (idx_next),
    .wrap     (wrap),
    .frame    (frame)
  );

  always_comb begin
    digit_sel = digit_0;
    case (idx_next)
      3'd1:    digit_sel = digit_1;
      3'd2:    digit_sel = digit_2;
      3'd3:    digit_sel = digit_3;
      3'd4:    digit_sel = digit_4;
      3'd5:    digit_sel = digit_5;
      default: digit_sel = digit_0;
    endcase
  end

  // The slot latches are loaded on the edge that enters cnt=0, so the whole
  // slot, including its blank window, sees one stable pattern and duty.
  assign slot_start    = enable && ((state == ST_IDLE) || wrap);
  assign seg_l_next    = slot_start ? digit_sel : seg_l;
  assign bright_l_next = slot_start ? bright : bright_l;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state    <= ST_IDLE;
      seg_l    <= '0;
      bright_l <= '0;
    end else begin
      state    <= state_next;
      seg_l    <= seg_l_next;
      bright_l <= bright_l_next;
    end
  end

  // Decoded from the counter's next value so that the registered state (and
  // the registered outputs) line up with the cnt of the cycle they occupy.
  always_comb begin
    on_end     = 32'(BLANK) + (32'(bright_l_next) + 32'd1) * 32'(ONSTEP);
    state_next = ST_OFF;
    if (!enable) begin
      state_next = ST_IDLE;
    end else if (32'(cnt_next) < 32'(BLANK)) begin
      state_next = ST_BLANK;
    end else if (32'(cnt_next) < on_end) begin
      state_next = ST_ON;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_next == ST_ON) begin
      an_d  = an_select(idx_next);
      seg_d = ~seg_l_next;
    end
  end

  // Registered outputs; the asynchronous reset darkens the display at once.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 1024: clock cycles per digit slot; (DIV-BLANK) SHALL be a positive multiple of 8.
REQ-002 Parameter BLANK, default 64: anti-ghost blank cycles at the start of each slot, 1 <= BLANK < DIV.
REQ-003 m_clock  in  1  system clock; all state changes on its rising edge.
REQ-004 p_reset  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  scan enable; 0 blanks the display and holds the scanner idle.
REQ-006 digit_0..digit_5  in  8 each  segment patterns from the hex decoder stage; active-high; bit7 = dp; digit_0 = least significant digit.
REQ-007 bright  in  3  brightness, 0 = 1/8 duty, 7 = full duty.
REQ-008 seg  out  8  shared segment bus, active-low, bit order as digit_n.
REQ-009 an  out  6  digit anode selects, active-low, one-hot-zero.
REQ-010 frame  out  1  one-cycle pulse at the end of each full 6-digit scan.

Function
REQ-011 ONSTEP SHALL equal (DIV-BLANK)/8, and ON_LEN SHALL equal (bright_l+1)*ONSTEP, where bright_l is bright latched at slot start.
REQ-012 Slot counter cnt SHALL count 0..DIV-1 while enabled, then wrap to 0 and advance slot index idx 0..5; idx SHALL wrap 5 -> 0.
REQ-013 At every slot start (cnt=0), digit_idx SHALL be latched into seg_l and bright into bright_l; changes to digit_n or bright mid-slot SHALL have no effect until the next slot.
REQ-014 States: IDLE, BLANK, ON, OFF.
REQ-015 BLANK SHALL apply for cnt in [0, BLANK-1], ON for [BLANK, BLANK+ON_LEN-1], and OFF for [BLANK+ON_LEN, DIV-1]; with bright=7, OFF SHALL never occur.
REQ-016 an and seg SHALL be registers, and during the cycle in which cnt=k they SHALL reflect the state for k.
REQ-017 In ON: an[idx]=0, all other an bits 1, seg = ~seg_l.
REQ-018 In IDLE, BLANK and OFF: an=6'b111111 and seg=8'hFF.
REQ-019 frame SHALL be 1 exactly in the cycle with idx=5 and cnt=DIV-1, and 0 otherwise.
REQ-020 When enable=0 is sampled, the next cycle SHALL be IDLE with cnt=0 and idx=0, regardless of the current slot position.
REQ-021 The first cycle after enable=1 is sampled in IDLE SHALL be slot 0, cnt=0, BLANK, with latching per REQ-013.
REQ-022 an SHALL never have more than one bit at 0 in any cycle, including the cycles at state transitions and at idx wrap.
REQ-023 The digit pattern SHALL pass through unmodified apart from inversion; there is no decoding in this block.

Reset
REQ-024 While p_reset=1: state=IDLE, cnt=0, idx=0, seg_l=0, bright_l=0, an=6'b111111, seg=8'hFF, frame=0.
REQ-025 Reset asserted mid-slot SHALL blank the outputs immediately, without waiting for a clock edge.
REQ-026 After reset release with enable=1, behaviour SHALL follow REQ-021.

Structure
REQ-027 Shared package seg7_pkg SHALL hold NUM_DIGITS=6, the state type/encoding, and the active-low blank constants SEG_OFF=8'hFF and AN_OFF=6'h3F.
REQ-028 The slot counter (cnt/idx/frame) SHALL be a sub-module seg7_slot_timer; the state decode and output registers SHALL reside in seg7_scan.

Verification (DIV=32, BLANK=8, so ONSTEP=3)
REQ-029 Reset, enable=1, digit_0=8'h3F, bright=7 -> cycles 0-7: an=3F, seg=FF; cycles 8-31: an=6'b111110, seg=8'hC0; cycle 32: BLANK for digit_1.
REQ-030 bright=0, digit_2=8'h5B -> slot 2 ON for cnt 8-10 only (an=6'b111011, seg=8'hA4); cnt 11-31 OFF, outputs blank.
REQ-031 Free-run 6 slots -> frame=1 at cycle 191 only; cycle 192 = slot 0 BLANK; the bench checks an is never multi-hot.
REQ-032 Change digit_1 from 8'h06 to 8'h7F at slot 1 cnt=15 -> seg stays 8'hF9 through cnt=31; the next visit to slot 1 shows 8'h80.
REQ-033 Drop enable at slot 3 cnt=20 -> next cycle IDLE, an=3F, seg=FF; re-enable -> slot 0 cnt=0 BLANK.
REQ-034 Assert p_reset asynchronously mid-ON in slot 4 -> an=3F and seg=FF before the next clock edge; frame=0.
